// File: rtl/bcd_pkg.sv
// Shared types and constants for BCD digit-entry blocks.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t  BCD_MAX   = 4'd9;
    localparam logic [13:0] MAX_VALUE = 14'd9999;

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

endpackage

// File: rtl/bcd_to_binary_if.sv
// Start/busy/done handshake bundle between a digit source and the BCD converter.
interface bcd_to_binary_if
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_WIDTH = 14
);

    logic                              start;
    bcd_digit_t [NUM_DIGITS-1:0]       digits_in;
    logic                              busy;
    logic                              done;
    logic       [VALUE_WIDTH-1:0]      value;
    logic                              digit_error;

    modport master (
        output start, digits_in,
        input  busy, done, value, digit_error
    );

    modport slave (
        input  start, digits_in,
        output busy, done, value, digit_error
    );

endinterface

// File: rtl/mul10_add.sv
// One step of decimal accumulation: acc*10 + digit, with a non-decimal digit flag.
module mul10_add
    import bcd_pkg::*;
#(
    parameter int VALUE_WIDTH = 14
) (
    input  logic [VALUE_WIDTH-1:0] acc,
    input  bcd_digit_t             digit,
    output logic [VALUE_WIDTH-1:0] sum,
    output logic                   bad
);

    localparam int W = VALUE_WIDTH + 4;

    // acc*10 as (acc<<3)+(acc<<1); only the error path can exceed VALUE_WIDTH
    assign sum = VALUE_WIDTH'((W'(acc) << 3) + (W'(acc) << 1) + W'(digit));
    assign bad = (digit > BCD_MAX);

endmodule

// File: rtl/bcd_to_binary.sv
// Iterative BCD-to-binary converter, most significant digit first, fixed latency.
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_WIDTH = 14
) (
    input  logic           clk,
    input  logic           reset_n,
    bcd_to_binary_if.slave bus
);

    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    state_t                      state, state_next;
    bcd_digit_t [NUM_DIGITS-1:0] digit_q;
    logic       [VALUE_WIDTH-1:0] acc, acc_next, value_q;
    logic       [IDX_W-1:0]      idx;
    logic                        err_seen, err_seen_next, digit_bad;
    logic                        digit_error_q;
    logic                        accept, last;

    mul10_add #(.VALUE_WIDTH(VALUE_WIDTH)) u_mul10_add (
        .acc   (acc),
        .digit (digit_q[idx]),
        .sum   (acc_next),
        .bad   (digit_bad)
    );

    assign err_seen_next = err_seen | digit_bad;
    // DONE accepts a new start like IDLE, giving back-to-back conversions
    assign accept        = bus.start && (state != CONVERT);
    assign last          = (idx == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CONVERT;
            CONVERT: if (last)   state_next = DONE;
            DONE:    state_next = accept ? CONVERT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            digit_q       <= '0;
            acc           <= '0;
            idx           <= '0;
            err_seen      <= 1'b0;
            value_q       <= '0;
            digit_error_q <= 1'b0;
        end else if (accept) begin
            digit_q  <= bus.digits_in;
            acc      <= '0;
            idx      <= IDX_LAST;
            err_seen <= 1'b0;
        end else if (state == CONVERT) begin
            acc      <= acc_next;
            err_seen <= err_seen_next;
            idx      <= idx - IDX_W'(1);
            if (last) begin
                value_q       <= err_seen_next ? '0 : acc_next;
                digit_error_q <= err_seen_next;
            end
        end
    end

    assign bus.busy        = (state == CONVERT);
    assign bus.done        = (state == DONE);
    assign bus.value       = value_q;
    assign bus.digit_error = digit_error_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed and round-trip checks of the BCD-to-binary converter handshake and results.
module tb_bcd_to_binary;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    bcd_to_binary_if #(.NUM_DIGITS(4), .VALUE_WIDTH(14)) bus ();

    bcd_to_binary #(.NUM_DIGITS(4), .VALUE_WIDTH(14)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    // Start on a negedge, then sample every following negedge: busy for 4, done on the 5th.
    task automatic convert(input string tag, input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0,
                           input int exp_val, input logic exp_err, input bit noise);
        @(negedge clk);
        bus.digits_in = {d3, d2, d1, d0};
        bus.start     = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (noise && i < 4) begin
                bus.start     = 1'b1;
                bus.digits_in = 16'(($urandom & 32'h0000_ffff));
            end else begin
                bus.start = 1'b0;
            end
            check({tag, ".busy_done"}, {30'd0, bus.busy, bus.done}, 32'b10);
        end
        @(negedge clk);
        check({tag, ".done"}, {30'd0, bus.busy, bus.done}, 32'b01);
        check({tag, ".value"}, 32'(bus.value), exp_val);
        check({tag, ".err"}, 32'(bus.digit_error), 32'(exp_err));
        @(negedge clk);
        check({tag, ".idle"}, {30'd0, bus.busy, bus.done}, 32'b00);
        check({tag, ".hold"}, 32'(bus.value), exp_val);
    endtask

    initial begin
        int n;
        checks        = 0;
        failures      = 0;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.digits_in = '0;

        repeat (2) @(negedge clk);
        check("rst.busy_done", {30'd0, bus.busy, bus.done}, 32'b00);
        check("rst.value", 32'(bus.value), 32'd0);
        check("rst.err", 32'(bus.digit_error), 32'd0);
        reset_n = 1'b1;

        convert("basic", 4'd1, 4'd2, 4'd3, 4'd4, 1234, 1'b0, 1'b0);
        convert("max",   4'd9, 4'd9, 4'd9, 4'd9, 9999, 1'b0, 1'b0);
        convert("zero",  4'd0, 4'd0, 4'd0, 4'd0, 0,    1'b0, 1'b0);
        convert("bad_a", 4'd1, 4'hA, 4'd0, 4'd0, 0,    1'b1, 1'b0);
        convert("ok42",  4'd0, 4'd0, 4'd4, 4'd2, 42,   1'b0, 1'b0);
        convert("bad_lo", 4'd0, 4'd0, 4'd0, 4'hF, 0,   1'b1, 1'b0);
        convert("bad_all", 4'hF, 4'hF, 4'hF, 4'hF, 0,  1'b1, 1'b0);
        convert("noise", 4'd8, 4'd0, 4'd6, 4'd1, 8061, 1'b0, 1'b1);

        // start held high: a new conversion every 5 cycles
        @(negedge clk);
        bus.digits_in = {4'd0, 4'd0, 4'd0, 4'd7};
        bus.start     = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check("b2b.done", 32'(bus.done), 32'((k % 5) == 0));
            if (k % 5 == 0) check("b2b.value", 32'(bus.value), 32'd7);
            if (k == 15) bus.start = 1'b0;
        end
        @(negedge clk);
        check("b2b.idle", {30'd0, bus.busy, bus.done}, 32'b00);

        // reset during the second CONVERT cycle abandons the conversion
        @(negedge clk);
        bus.digits_in = {4'd3, 4'd3, 4'd3, 4'd3};
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst.busy_done", {30'd0, bus.busy, bus.done}, 32'b00);
        check("midrst.value", 32'(bus.value), 32'd0);
        check("midrst.err", 32'(bus.digit_error), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("midrst.nodone", {30'd0, bus.busy, bus.done}, 32'b00);
        end
        convert("after_rst", 4'd5, 4'd0, 4'd0, 4'd5, 5005, 1'b0, 1'b0);

        // round trip through a decimal digit split
        for (int s = 0; s < 1000; s++) begin
            n = int'($urandom_range(9999, 0));
            convert("trip", 4'((n / 1000) % 10), 4'((n / 100) % 10),
                    4'((n / 10) % 10), 4'(n % 10), n, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential converter from four BCD digits (thousands..ones) to a 14-bit binary value 0-9999. It is the inverse of the display path's binary-to-digit separation and sits on the input side, after keypad or switch digit entry, feeding binary values to counters and comparators. It uses an iterative multiply-by-10-and-add datapath instead of a combinational tree. The interface is a start/busy/done handshake and flags any non-decimal digit.

## Interface
- NUM_DIGITS, 4, number of BCD digits converted; index 0 is the ones digit.
- VALUE_WIDTH, 14, binary result width; must hold 10^NUM_DIGITS-1.
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  reset; one clock, synchronous, active-low.
- start  input  1  conversion request; sampled only when busy=0.
- digits_in  input  [NUM_DIGITS-1:0][3:0]  BCD digits, [3]=thousands, [0]=ones; captured on the accepting edge.
- busy  output  1  conversion in progress; start ignored while high.
- done  output  1  one-cycle pulse; value and digit_error valid and updated.
- value  output  VALUE_WIDTH  converted result; holds until next done.
- digit_error  output  1  last conversion saw a digit >9; holds until next done.

## Operation
- FSM states: IDLE, CONVERT, DONE.
- IDLE: busy=0, done=0.
  - start=1 at an edge: capture digits_in into the digit register, clear acc, set idx=NUM_DIGITS-1, clear err_seen, go to CONVERT.
- CONVERT: busy=1. Each edge:
  - acc <= acc*10 + digit[idx], with acc*10 formed as (acc<<3)+(acc<<1) in VALUE_WIDTH+4 bits, truncated to VALUE_WIDTH.
  - err_seen <= err_seen | (digit[idx] > 9).
  - idx decrements.
  - At the edge that processes idx=0:
    - value <= err_seen_next ? 0 : acc_next.
    - digit_error <= err_seen_next.
    - done <= 1.
    - go to DONE.
- DONE: busy=0, done=1 for exactly this cycle.
  - start=1 here is accepted exactly as in IDLE: back-to-back operation, go to CONVERT.
  - Otherwise go to IDLE.
- Digits are processed MSD first. An invalid digit does not stop the conversion; latency is fixed.
- digits_in changes after the capture edge have no effect on the result.

## Timing
- Reset (reset_n=0 at an edge) forces:
  - state=IDLE
  - busy=0, done=0, value=0, digit_error=0
  - acc, idx and digit register cleared.
- Reset mid-conversion abandons the conversion: no done pulse, value unchanged from its reset value of 0.
- Latency: start sampled at edge E0. busy is high for the NUM_DIGITS cycles after E0. done, value and digit_error update at edge E(NUM_DIGITS).
- Throughput: one conversion per NUM_DIGITS+1 cycles with start held high.
- start while busy=1 is dropped, not queued.
- Valid digits never overflow VALUE_WIDTH (max 9999 < 16384), so truncation only affects the discarded error path.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package bcd_pkg holds:
  - typedef bcd_digit_t (logic [3:0])
  - BCD_MAX = 4'd9
  - MAX_VALUE = 14'd9999
  - state enum {IDLE, CONVERT, DONE}
- One natural sub-module, mul10_add: combinational acc*10+digit plus the digit>9 flag, reusable by other digit-entry blocks.
- The top holds the FSM, digit register, idx counter and output registers.

## Test plan
- **Basic conversion:** digits 1,2,3,4, start pulse → busy high 4 cycles; done=1 exactly 4 clocks after the start edge; value=1234 (0x04D2), digit_error=0.
- **Extremes:**
  - 9,9,9,9 → value=9999.
  - 0,0,0,0 → value=0.
  - Both with done pulse width exactly 1 cycle.
- **Invalid digit:**
  - 1,A,0,0 → value=0, digit_error=1.
  - Next conversion 0,0,4,2 → value=42, digit_error=0.
- **Back-to-back and dropped starts:**
  - start held high with 0,0,0,7 → done every 5 cycles, value=7.
  - Start pulses and digits_in changes while busy=1 are ignored.
- **Reset mid-conversion:**
  - reset_n low for one edge at the second CONVERT cycle → all outputs 0, no done.
  - Next start with 5,0,0,5 → value=5005.
- **Round trip:** random 0-9999 split into digits by the display digit separator, then converted → value equals the original for ≥1000 samples.
